// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the 5-bit ALU sequencer/logger pair:
//            opcode encodings, default operand width and the bit offsets of
//            the fields inside a logged result word {V, C, Z, OP, result}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Default operand/result width, shared with the operand sequencer.
    localparam int ALU_WIDTH = 5;

    // Opcode encodings.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Field offsets inside a result word for the default width.
    // The word is {V, C, Z, OP, result[ALU_WIDTH-1:0]}.
    localparam int RES_LSB = 0;
    localparam int OP_BIT  = ALU_WIDTH;
    localparam int Z_BIT   = ALU_WIDTH + 1;
    localparam int C_BIT   = ALU_WIDTH + 2;
    localparam int V_BIT   = ALU_WIDTH + 3;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module   : result_fifo
// Purpose  : Parameterised show-ahead FIFO. The head entry is presented on
//            data_o whenever the FIFO is not empty (0 when empty). A push
//            into a full FIFO without a same-cycle pop is refused and flagged
//            on drop_o for that cycle.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            push_i, data_i  - write request and data
//            pop_i           - read request (ignored while empty)
//            data_o, valid_o - head entry / not-empty
//            full_o          - DEPTH entries held
//            accept_o        - push was written this cycle
//            drop_o          - push was discarded this cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o,
    output logic         accept_o,
    output logic         drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    logic w_pop;

    assign valid_o  = (cnt_q != '0);
    assign full_o   = (cnt_q == C_DEPTH_CNT);
    assign w_pop    = pop_i && valid_o;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the head is leaving.
    assign accept_o = push_i && (!full_o || w_pop);
    assign drop_o   = push_i && full_o && !w_pop;
    assign data_o   = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept_o) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({accept_o, w_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the occupancy counter masks stale entries.
    always_ff @(posedge clk) begin
        if (accept_o) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : result_fifo

`default_nettype wire

// File: rtl/alu_exec_logger.sv
// ============================================================================
// Module   : alu_exec_logger
// Purpose  : Samples A/B/OP on in_valid, executes add/sub with V/C/Z flags
//            one cycle later and logs {V, C, Z, OP, result} into a
//            show-ahead result FIFO. Counts logged results (wrapping) and
//            keeps a sticky flag for results dropped on a full FIFO.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid, A, B, OP    - operation input (OP: 0 add, 1 sub)
//            rd_en                 - pop the FIFO head
//            out_valid, out_word   - FIFO not empty / head entry
//            full                  - FIFO holds DEPTH entries
//            op_count              - results written, modulo 2^CNT_W
//            drop_err              - sticky overflow-drop flag
// Macro    : ALU_SAT_EN - unsigned saturation of the result on carry/borrow
//            (flags still report the raw condition; Z follows the
//            saturated result). Port list is identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_logger
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             OP,
    input  logic             rd_en,
    output logic             out_valid,
    output logic [WIDTH+3:0] out_word,
    output logic             full,
    output logic [CNT_W-1:0] op_count,
    output logic             drop_err
);

    // Stage 1: operand registers
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             s1_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
        end
    end

    // Data registers hold their value while no operation is issued.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= OP;
        end
    end

    // Stage 2: execute; the FIFO write is the stage-2 register
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_zero;
    logic [WIDTH+3:0] w_word;

    assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
    // The extra MSB of the widened difference is the unsigned borrow.
    assign w_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        w_raw   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_sum[WIDTH-1] != a_q[WIDTH-1]);
        if (op_q == OP_SUB) begin
            w_raw   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
            w_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_diff[WIDTH-1] != a_q[WIDTH-1]);
        end
        w_res = w_raw;
`ifdef ALU_SAT_EN
        // Clamp to the unsigned range: carry on add saturates high,
        // borrow on subtract saturates low.
        if (w_carry) begin
            w_res = (op_q == OP_SUB) ? '0 : '1;
        end
`endif
        w_zero = (w_res == '0);
        w_word = {w_ovf, w_carry, w_zero, op_q, w_res};
    end

    // Result FIFO
    logic w_accept;
    logic w_drop;

    result_fifo #(
        .W     (WIDTH + 4),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (s1_valid_q),
        .data_i   (w_word),
        .pop_i    (rd_en),
        .data_o   (out_word),
        .valid_o  (out_valid),
        .full_o   (full),
        .accept_o (w_accept),
        .drop_o   (w_drop)
    );

    // Counter and sticky drop flag
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             drop_q;
    logic             drop_d;

    assign cnt_d  = w_accept ? cnt_q + CNT_W'(1) : cnt_q;
    assign drop_d = drop_q || w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign op_count = cnt_q;
    assign drop_err = drop_q;

endmodule : alu_exec_logger

`default_nettype wire

// File: tb/tb_alu_exec_logger.sv
// ============================================================================
// Module   : tb_alu_exec_logger
// Purpose  : Self-checking bench for alu_exec_logger (WIDTH=5, DEPTH=4,
//            CNT_W=8). Directed vectors from the test plan followed by
//            randomized traffic, all compared against a queue-based
//            reference model. Honors ALU_SAT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_logger;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] A;
    logic [4:0] B;
    logic       OP;
    logic       rd_en;
    logic       out_valid;
    logic [8:0] out_word;
    logic       full;
    logic [7:0] op_count;
    logic       drop_err;

    always #5 clk = ~clk;

    alu_exec_logger #(
        .WIDTH (5),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_word  (out_word),
        .full      (full),
        .op_count  (op_count),
        .drop_err  (drop_err)
    );

    // Reference model state
    logic [8:0] m_q[$];
    logic       m_pend_v;
    logic [8:0] m_pend_w;
    logic [7:0] m_cnt;
    logic       m_drop;

    int n_cmp = 0;
    int n_bad = 0;

    // Arithmetic reference: integer math on signed/unsigned interpretations.
    function automatic logic [8:0] ref_alu(input int a, input int b, input bit op);
        int sa;
        int sb;
        int r;
        int sr;
        bit c;
        bit v;
        sa = (a >= 16) ? a - 32 : a;
        sb = (b >= 16) ? b - 32 : b;
        if (!op) begin
            r  = a + b;
            c  = (r >= 32);
            sr = sa + sb;
        end else begin
            r  = a - b;
            c  = (a < b);
            sr = sa - sb;
        end
        v = (sr > 15) || (sr < -16);
        r = (r + 32) % 32;
`ifdef ALU_SAT_EN
        if (c) r = op ? 0 : 31;
`endif
        return {v, c, (r == 0), op, 5'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("out_word", 32'(out_word), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("full", 32'(full), 32'(m_q.size() == 4));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
    endtask

    // One clock: drive at negedge, update model at posedge, check next negedge.
    task automatic step(input bit rst, input bit v, input logic [4:0] a,
                        input logic [4:0] b, input bit op, input bit rd);
        bit pop_ok;
        reset = rst; in_valid = v; A = a; B = b; OP = op; rd_en = rd;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pend_v = 1'b0;
            m_cnt    = '0;
            m_drop   = 1'b0;
        end else begin
            pop_ok = rd && (m_q.size() != 0);
            if (pop_ok) void'(m_q.pop_front());
            if (m_pend_v) begin
                if (m_q.size() < 4) begin
                    m_q.push_back(m_pend_w);
                    m_cnt = m_cnt + 8'd1;
                end else begin
                    m_drop = 1'b1;
                end
            end
            m_pend_v = v;
            m_pend_w = ref_alu(int'(a), int'(b), op);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, rd);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; OP = 1'b0; rd_en = 1'b0;
        m_pend_v = 1'b0; m_pend_w = '0; m_cnt = '0; m_drop = 1'b0;
        @(negedge clk);

        // Reset then idle
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("rst_out_word", 32'(out_word), 32'd0);
        idle(2, 1'b1);

        // Sequencer pattern: first result visible 2 cycles after sampling
        step(1'b0, 1'b1, 5'b11100, 5'b00011, 1'b0, 1'b0);
        chk("lat_n", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 5'b10100, 5'b00010, 1'b1, 1'b0);
        chk("lat_n1", 32'(out_valid), 32'd1);
        chk("seq_e0", 32'(out_word), 32'b0_0_0_0_11111);
        step(1'b0, 1'b1, 5'b11100, 5'b00100, 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("seq_cnt", 32'(op_count), 32'd3);
        idle(1, 1'b1);
        chk("seq_e1", 32'(out_word), 32'b0_0_0_1_10010);
        idle(1, 1'b1);
        chk("seq_e2", 32'(out_word), 32'b0_0_0_1_11000);
        idle(2, 1'b1);

        // Flag vectors
        step(1'b0, 1'b1, 5'b01111, 5'b00001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'b00011, 5'b00011, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5'b00010, 5'b00101, 1'b1, 1'b0);
        chk("ovf_add", 32'(out_word), 32'b1_0_0_0_10000);
        idle(1, 1'b1);
        chk("zero_sub", 32'(out_word), 32'b0_0_1_1_00000);
        idle(1, 1'b1);
`ifdef ALU_SAT_EN
        chk("borrow_sat", 32'(out_word), 32'b0_1_1_1_00000);
`else
        chk("borrow_sub", 32'(out_word), 32'b0_1_0_1_11101);
`endif
        idle(2, 1'b1);

        // Saturation vector (wraps without the macro)
        step(1'b0, 1'b1, 5'b11111, 5'b00001, 1'b0, 1'b0);
        idle(1, 1'b0);
`ifdef ALU_SAT_EN
        chk("carry_sat", 32'(out_word), 32'b0_1_0_0_11111);
`else
        chk("carry_wrap", 32'(out_word), 32'b0_1_1_0_00000);
`endif
        idle(2, 1'b1);

        // Fill and drop
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'(i + 1), 5'd1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_drop", 32'(drop_err), 32'd1);
        chk("fill_cnt", 32'(op_count), 32'd4);
        chk("fill_head", 32'(out_word), 32'b0_0_0_0_00010);
        idle(4, 1'b1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset with two entries queued
        step(1'b0, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd7, 5'd8, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 1'b0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_err), 32'd0);
        idle(2, 1'b0);

        // Simultaneous push/pop while full
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'(i), 5'(i + 2), 1'b1 & i[0], 1'b0);
        step(1'b0, 1'b1, 5'd10, 5'd3, 1'b0, 1'b0);
        chk("pp_full0", 32'(full), 32'd1);
        step(1'b0, 1'b1, 5'd11, 5'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("pp_full1", 32'(full), 32'd1);
        chk("pp_cnt", 32'(op_count), 32'd6);
        chk("pp_drop", 32'(drop_err), 32'd0);
        idle(6, 1'b1);
        // rd_en while empty
        idle(2, 1'b1);
        chk("empty_pop", 32'(out_valid), 32'd0);

        // Randomized traffic (enough pushes to wrap op_count)
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_exec_logger

`default_nettype wire

// File: doc/alu_exec_logger.md
Name: alu_exec_logger

Overview:
- Downstream consumer of the operand/opcode sequencer for the 5-bit ALU.
- Samples operands A and B plus the opcode OP whenever in_valid is high, and executes them in a 2-stage registered ALU (add/sub with flags).
- Pushes each result word into a small show-ahead result FIFO, which a monitor or display stage drains with rd_en.
- Keeps a wrapping count of executed operations and a sticky overflow-drop error.

Parameters:
- WIDTH, 5, operand/result width in bits.
- DEPTH, 4, result FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 8, width of op_count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B/OP are valid this cycle; the top level drives it high in operand-issuing states.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OP  input  1  opcode: 0 = add (A+B), 1 = subtract (A-B).
- rd_en  input  1  pop the FIFO head.
- out_valid  output  1  FIFO not empty; out_word is meaningful.
- out_word  output  WIDTH+4  head entry, packed {V, C, Z, OP, result[WIDTH-1:0]}.
- full  output  1  FIFO holds DEPTH entries.
- op_count  output  CNT_W  number of results written into the FIFO; wraps modulo 2^CNT_W.
- drop_err  output  1  sticky flag: a result was discarded because the FIFO was full.

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous and active-high; nothing else is reset asynchronously.
  - On reset, every output goes to 0: out_valid=0, out_word=0, full=0, op_count=0, drop_err=0. Pipeline valid bits and FIFO pointers also clear.
  - Reset asserted mid-operation discards in-flight stage-1/stage-2 contents and all FIFO entries.
- Stage 1 (edge N, when in_valid=1): register A, B, OP and s1_valid=1. When in_valid=0, s1_valid=0 and the data registers hold.
- Stage 2 (edge N+1, if s1_valid=1): compute, then push {V, C, Z, OP, result} into the FIFO.
  - With no pop, out_valid rises after edge N+1: 2-cycle latency from sample to visible.
- Add: sum = A+B computed at WIDTH+1 bits.
  - result = sum[WIDTH-1:0]; C = sum[WIDTH] (carry out).
  - V = signed overflow: operands have the same sign and the result sign differs.
- Sub: result = (A-B) mod 2^WIDTH.
  - C = borrow, 1 iff A < B unsigned.
  - V = operands have different signs and the result sign differs from A.
- Z = 1 iff result == 0 (after saturation, when the optional feature is enabled).
- FIFO:
  - Show-ahead: out_word always equals the head entry while out_valid=1, and holds 0 when empty.
  - Pop with rd_en=1 and out_valid=1 takes effect at the edge. rd_en while empty is ignored, with no pointer change.
  - Push while full and no pop in the same cycle: the entry is dropped, drop_err is set to 1 and stays at 1 until reset, and op_count does not increment.
  - Simultaneous push and pop while full is legal: occupancy is unchanged and no drop occurs.
  - Simultaneous push and pop while empty: the entry is written; the pop is ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally. An occupancy counter of log2(DEPTH)+1 bits drives full and out_valid.
- op_count increments by 1 on each successful push and wraps from 2^CNT_W-1 to 0.
- Back-to-back in_valid is supported at 1 op per cycle with no stalls. There is no backpressure on the input; only the drop mechanism protects a full FIFO.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: unsigned saturation.
  - Add with C=1 gives result = all ones.
  - Sub with C=1 gives result = 0.
  - C and V still report the raw condition; Z is evaluated on the saturated result.
- Undefined: modular wrap-around as specified under Behaviour. The logic is absent and the port list is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=1'b0, OP_SUB=1'b1;
  - result-word field offsets (RES_LSB, OP_BIT, Z_BIT, C_BIT, V_BIT);
  - the default WIDTH constant, shared with the sequencer.
- One sub-module, result_fifo: a parameterised show-ahead FIFO providing push, pop, full, empty and drop detection. The ALU datapath and counter stay in the top module.

Test Plan:
- Reset, then idle: out_valid=0, out_word=0, op_count=0, drop_err=0. Reset asserted with 2 entries queued leaves all outputs 0 on the next cycle.
- Sequencer pattern A=11100,B=00011,OP=0; A=10100,B=00010,OP=1; A=11100,B=00100,OP=1 on consecutive cycles. First out_valid 2 cycles after the first sample; entries in order:
  - result=11111, Z=0, C=0, V=0;
  - result=10010, C=0, V=0;
  - result=11000, C=0, V=0.
  - op_count=3.
- Overflow/flags:
  - 01111+00001 gives 10000, V=1, C=0.
  - 00011-00011 gives 00000, Z=1, C=0.
  - 00010-00101 gives 11101, C=1.
- Fill and drop: 5 back-to-back ops with rd_en=0 and DEPTH=4 gives full=1, drop_err=1 and op_count=4; the 5th result is absent after draining.
- Simultaneous push/pop while full: op_count increments, occupancy stays 4, drop_err stays 0. rd_en on empty produces no change.
- ALU_SAT_EN build:
  - 11111+00001 gives result 11111 with C=1.
  - 00010-00101 gives result 00000 with Z=1, C=1.
  - Without the macro, the same stimulus gives 00000 (Z=1, C=1) and 11101 (C=1).
